fc_l2_port_demux: RTL and testbench

//  Routes one FC core TCDM-style request stream (instr or data) to one of two L2 master ports:

---
 rtl/fc_l2_port_demux.sv | 161 ++++++++++++++++
 tb/tb_fc_l2_port_demux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fc_l2_port_demux.sv
// FC core request demux onto the interleaved L2 (port0) and the private SCM bank (port1).
// Optional alias SCM window is enabled with the FC_L2_DEMUX_ALIAS_EN macro.
module fc_l2_port_demux #(
  parameter int unsigned           ADDR_WIDTH       = 32,
  parameter int unsigned           DATA_WIDTH       = 32,
  parameter int unsigned           MAX_OUTSTANDING  = 2,
  parameter logic [ADDR_WIDTH-1:0] SCM_START_ADDR   = 32'h1C00_0000,
  parameter logic [ADDR_WIDTH-1:0] SCM_END_ADDR     = 32'h1C00_8000,
  parameter logic [ADDR_WIDTH-1:0] ALIAS_START_ADDR = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ALIAS_END_ADDR   = 32'h0000_8000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    slv_req_i,
  input  logic [ADDR_WIDTH-1:0]   slv_add_i,
  input  logic                    slv_wen_i,
  input  logic [DATA_WIDTH-1:0]   slv_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] slv_be_i,
  output logic                    slv_gnt_o,
  output logic                    slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]   slv_r_rdata_o,
  output logic                    m0_req_o,
  output logic [ADDR_WIDTH-1:0]   m0_add_o,
  output logic                    m0_wen_o,
  output logic [DATA_WIDTH-1:0]   m0_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m0_be_o,
  input  logic                    m0_gnt_i,
  input  logic                    m0_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   m0_r_rdata_i,
  output logic                    m1_req_o,
  output logic [ADDR_WIDTH-1:0]   m1_add_o,
  output logic                    m1_wen_o,
  output logic [DATA_WIDTH-1:0]   m1_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m1_be_o,
  input  logic                    m1_gnt_i,
  input  logic                    m1_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   m1_r_rdata_i,
  output logic                    err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] lo,
                                     input logic [ADDR_WIDTH-1:0] hi);
    return (addr >= lo) && (addr < hi);
  endfunction

  logic [CW-1:0] cnt_r;
  logic          act_port_r;
  logic          sel_s;
  logic          allow_s;
  logic          accept_s;
  logic          rsp_s;
  logic          cnt_zero_s;
  logic [CW-1:0] cnt_eff_s;
  logic [CW-1:0] cnt_nxt_s;

  // Address decode to the target port
  always_comb begin
    sel_s = 1'b0;
`ifdef FC_L2_DEMUX_ALIAS_EN
    if (in_window(slv_add_i, SCM_START_ADDR, SCM_END_ADDR) ||
        in_window(slv_add_i, ALIAS_START_ADDR, ALIAS_END_ADDR)) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
`else
    if (in_window(slv_add_i, SCM_START_ADDR, SCM_END_ADDR)) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
`endif
  end

  // Response steering, in-order check and spurious-response detection
  always_comb begin
    cnt_zero_s    = (cnt_r == CNT_ZERO);
    rsp_s         = 1'b0;
    slv_r_rdata_o = m0_r_rdata_i;
    err_o         = 1'b0;
    if (act_port_r) begin
      rsp_s         = m1_r_valid_i & ~cnt_zero_s;
      slv_r_rdata_o = m1_r_rdata_i;
      err_o         = m0_r_valid_i | (m1_r_valid_i & cnt_zero_s);
    end else begin
      rsp_s         = m0_r_valid_i & ~cnt_zero_s;
      slv_r_rdata_o = m0_r_rdata_i;
      err_o         = m1_r_valid_i | (m0_r_valid_i & cnt_zero_s);
    end
    slv_r_valid_o = rsp_s;
  end

  // Request gating: a response this cycle frees its slot immediately (zero-bubble)
  always_comb begin
    cnt_eff_s = cnt_r - CW'(rsp_s);
    allow_s   = (cnt_eff_s == CNT_ZERO) |
                ((sel_s == act_port_r) & (cnt_eff_s < CNT_MAX));
    m0_req_o  = slv_req_i & allow_s & ~sel_s;
    m1_req_o  = slv_req_i & allow_s & sel_s;
    if (sel_s) begin
      slv_gnt_o = allow_s & m1_gnt_i;
    end else begin
      slv_gnt_o = allow_s & m0_gnt_i;
    end
    accept_s  = slv_req_i & slv_gnt_o;
  end

  // Request payload is broadcast to both ports
  always_comb begin
    m0_add_o   = slv_add_i;
    m0_wen_o   = slv_wen_i;
    m0_wdata_o = slv_wdata_i;
    m0_be_o    = slv_be_i;
    m1_add_o   = slv_add_i;
    m1_wen_o   = slv_wen_i;
    m1_wdata_o = slv_wdata_i;
    m1_be_o    = slv_be_i;
  end

  // Outstanding counter next value, saturating at both ends
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({accept_s, rsp_s})
      2'b10: begin
        if (cnt_r != CNT_MAX) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Outstanding count and active port registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r      <= CNT_ZERO;
      act_port_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (accept_s) begin
        act_port_r <= sel_s;
      end
    end
  end

endmodule

// File: tb/tb_fc_l2_port_demux.sv
// Directed self-checking bench for fc_l2_port_demux (default MAX_OUTSTANDING=2).
// Expectations for the alias step follow FC_L2_DEMUX_ALIAS_EN.
module tb_fc_l2_port_demux;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        slv_req;
  logic [31:0] slv_add;
  logic        slv_wen;
  logic [31:0] slv_wdata;
  logic [3:0]  slv_be;
  logic        slv_gnt, slv_r_valid;
  logic [31:0] slv_r_rdata;
  logic        m0_req, m0_wen, m1_req, m1_wen;
  logic [31:0] m0_add, m0_wdata, m1_add, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_r_valid, m1_gnt, m1_r_valid;
  logic [31:0] m0_r_rdata, m1_r_rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fc_l2_port_demux dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .slv_req_i(slv_req), .slv_add_i(slv_add), .slv_wen_i(slv_wen),
    .slv_wdata_i(slv_wdata), .slv_be_i(slv_be),
    .slv_gnt_o(slv_gnt), .slv_r_valid_o(slv_r_valid), .slv_r_rdata_o(slv_r_rdata),
    .m0_req_o(m0_req), .m0_add_o(m0_add), .m0_wen_o(m0_wen), .m0_wdata_o(m0_wdata),
    .m0_be_o(m0_be), .m0_gnt_i(m0_gnt), .m0_r_valid_i(m0_r_valid), .m0_r_rdata_i(m0_r_rdata),
    .m1_req_o(m1_req), .m1_add_o(m1_add), .m1_wen_o(m1_wen), .m1_wdata_o(m1_wdata),
    .m1_be_o(m1_be), .m1_gnt_i(m1_gnt), .m1_r_valid_i(m1_r_valid), .m1_r_rdata_i(m1_r_rdata),
    .err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    slv_req = 1'b0; slv_add = 32'h0; slv_wen = 1'b1; slv_wdata = 32'h0; slv_be = 4'hF;
    m0_gnt = 1'b0; m0_r_valid = 1'b0; m0_r_rdata = 32'h0;
    m1_gnt = 1'b0; m1_r_valid = 1'b0; m1_r_rdata = 32'h0;
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    idle();
    rst_ni = 1'b0;
    #2;
    check("rst_m0_req", {31'b0, m0_req}, 32'd0);
    check("rst_m1_req", {31'b0, m1_req}, 32'd0);
    check("rst_gnt", {31'b0, slv_gnt}, 32'd0);
    check("rst_rvalid", {31'b0, slv_r_valid}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_cnt", {30'b0, dut.cnt_r}, 32'd0);
    #10 rst_ni = 1'b1;
    tick();

    // 1: single SCM read, response next cycle
    slv_req = 1'b1; slv_add = 32'h1C00_0010; slv_wdata = 32'h1234_5678; slv_be = 4'h5; m1_gnt = 1'b1;
    #1;
    check("t1_m1_req", {31'b0, m1_req}, 32'd1);
    check("t1_m0_req", {31'b0, m0_req}, 32'd0);
    check("t1_gnt", {31'b0, slv_gnt}, 32'd1);
    check("t1_m0_add_bcast", m0_add, 32'h1C00_0010);
    check("t1_m1_wdata", m1_wdata, 32'h1234_5678);
    check("t1_m0_be", {28'b0, m0_be}, 32'h5);
    tick();
    check("t1_cnt1", {30'b0, dut.cnt_r}, 32'd1);
    idle(); m1_r_valid = 1'b1; m1_r_rdata = 32'hDEAD_BEEF;
    #1;
    check("t1_rvalid", {31'b0, slv_r_valid}, 32'd1);
    check("t1_rdata", slv_r_rdata, 32'hDEAD_BEEF);
    check("t1_err", {31'b0, err}, 32'd0);
    tick();
    check("t1_cnt0", {30'b0, dut.cnt_r}, 32'd0);

    // 2: fill to MAX_OUTSTANDING on port0, then free a slot
    idle(); slv_req = 1'b1; slv_add = 32'h1C01_0000; m0_gnt = 1'b1;
    #1;
    check("t2_a_gnt", {31'b0, slv_gnt}, 32'd1);
    check("t2_a_m0_req", {31'b0, m0_req}, 32'd1);
    tick();
    #1;
    check("t2_b_gnt", {31'b0, slv_gnt}, 32'd1);
    tick();
    check("t2_cnt2", {30'b0, dut.cnt_r}, 32'd2);
    #1;
    check("t2_full_gnt", {31'b0, slv_gnt}, 32'd0);
    check("t2_full_m0_req", {31'b0, m0_req}, 32'd0);
    check("t2_full_m1_req", {31'b0, m1_req}, 32'd0);
    tick();
    check("t2_cnt_hold", {30'b0, dut.cnt_r}, 32'd2);
    m0_r_valid = 1'b1; m0_r_rdata = 32'h1111_1111;
    #1;
    check("t2_free_rvalid", {31'b0, slv_r_valid}, 32'd1);
    check("t2_free_rdata", slv_r_rdata, 32'h1111_1111);
    check("t2_free_gnt", {31'b0, slv_gnt}, 32'd1);
    check("t2_free_m0_req", {31'b0, m0_req}, 32'd1);
    tick();
    check("t2_cnt_same", {30'b0, dut.cnt_r}, 32'd2);
    slv_req = 1'b0; m0_r_rdata = 32'h2222_2222;
    tick();
    check("t2_cnt_dec", {30'b0, dut.cnt_r}, 32'd1);
    m0_r_rdata = 32'h3333_3333;
    #1;
    check("t2_last_rdata", slv_r_rdata, 32'h3333_3333);
    tick();
    check("t2_cnt_drain", {30'b0, dut.cnt_r}, 32'd0);

    // 3: switch port0 -> port1 with zero bubble
    idle(); slv_req = 1'b1; slv_add = 32'h1C01_0000; m0_gnt = 1'b1;
    tick();
    check("t3_cnt1", {30'b0, dut.cnt_r}, 32'd1);
    slv_add = 32'h1C00_0000; m1_gnt = 1'b1;
    #1;
    check("t3_hold_m1_req", {31'b0, m1_req}, 32'd0);
    check("t3_hold_m0_req", {31'b0, m0_req}, 32'd0);
    check("t3_hold_gnt", {31'b0, slv_gnt}, 32'd0);
    tick();
    check("t3_cnt_hold", {30'b0, dut.cnt_r}, 32'd1);
    m0_r_valid = 1'b1; m0_r_rdata = 32'hAAAA_0001;
    #1;
    check("t3_sw_m1_req", {31'b0, m1_req}, 32'd1);
    check("t3_sw_gnt", {31'b0, slv_gnt}, 32'd1);
    check("t3_sw_rdata", slv_r_rdata, 32'hAAAA_0001);
    tick();
    check("t3_cnt_after_sw", {30'b0, dut.cnt_r}, 32'd1);
    idle(); m1_r_valid = 1'b1; m1_r_rdata = 32'hBBBB_0002;
    #1;
    check("t3_rvalid2", {31'b0, slv_r_valid}, 32'd1);
    check("t3_rdata2", slv_r_rdata, 32'hBBBB_0002);
    tick();
    check("t3_cnt0", {30'b0, dut.cnt_r}, 32'd0);

    // 4: spurious response with nothing outstanding
    idle(); m1_r_valid = 1'b1; m1_r_rdata = 32'hCAFE_0000;
    #1;
    check("t4_rvalid", {31'b0, slv_r_valid}, 32'd0);
    check("t4_err", {31'b0, err}, 32'd1);
    tick();
    idle();
    #1;
    check("t4_err_clr", {31'b0, err}, 32'd0);
    check("t4_cnt", {30'b0, dut.cnt_r}, 32'd0);

    // 4b: response on the non-active port while busy
    slv_req = 1'b1; slv_add = 32'h2000_0000; m0_gnt = 1'b1;
    tick();
    idle(); m1_r_valid = 1'b1;
    #1;
    check("t4b_rvalid", {31'b0, slv_r_valid}, 32'd0);
    check("t4b_err", {31'b0, err}, 32'd1);
    tick();
    check("t4b_cnt", {30'b0, dut.cnt_r}, 32'd1);
    idle(); m0_r_valid = 1'b1;
    #1;
    check("t4b_err_ok", {31'b0, err}, 32'd0);
    tick();
    check("t4b_cnt0", {30'b0, dut.cnt_r}, 32'd0);

    // 5: reset mid-operation with cnt=2
    idle(); slv_req = 1'b1; slv_add = 32'h1C01_0000; m0_gnt = 1'b1;
    tick();
    tick();
    check("t5_cnt2", {30'b0, dut.cnt_r}, 32'd2);
    idle();
    rst_ni = 1'b0;
    #1;
    check("t5_cnt_rst", {30'b0, dut.cnt_r}, 32'd0);
    #3 rst_ni = 1'b1;
    tick();
    m0_r_valid = 1'b1; m0_r_rdata = 32'h5555_5555;
    #1;
    check("t5_rvalid", {31'b0, slv_r_valid}, 32'd0);
    check("t5_err", {31'b0, err}, 32'd1);
    tick();
    check("t5_cnt", {30'b0, dut.cnt_r}, 32'd0);

    // 6: alias window address
    idle(); slv_req = 1'b1; slv_add = 32'h0000_0100; m0_gnt = 1'b1; m1_gnt = 1'b1;
    #1;
`ifdef FC_L2_DEMUX_ALIAS_EN
    check("t6_m1_req", {31'b0, m1_req}, 32'd1);
    check("t6_m0_req", {31'b0, m0_req}, 32'd0);
`else
    check("t6_m1_req", {31'b0, m1_req}, 32'd0);
    check("t6_m0_req", {31'b0, m0_req}, 32'd1);
`endif
    check("t6_gnt", {31'b0, slv_gnt}, 32'd1);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
